// File: rtl/vec_stream_tx.sv
// rtl/vec_stream_tx.sv - double-buffered N-word vector transmitter (optional m_last via VEC_TX_LAST_EN)
module vec_stream_tx #(
    parameter int N    = 2,
    parameter int T    = 9,
    parameter int logN = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [T-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [T-1:0] m_data,
`ifdef VEC_TX_LAST_EN
    output logic         m_last,
`endif
    output logic         idle
);

    // Banks are sized to the full counter range so counters index them directly.
    localparam int              DEPTH = 2 ** logN;
    localparam logic [logN-1:0] LAST  = logN'(N - 1);
    localparam logic [logN-1:0] ONE   = logN'(1);

    logic [T-1:0]    mem [2][DEPTH];
    logic            wb;
    logic            rb;
    logic [logN-1:0] wcnt;
    logic [logN-1:0] rcnt;
    logic [1:0]      full;
    logic [1:0]      full_nxt;

    logic wr_en;
    logic wr_last;
    logic out_free;
    logic rd_en;
    logic rd_last;

    assign s_ready  = !full[wb] && !reset;
    assign wr_en    = s_valid && s_ready;
    assign wr_last  = wr_en && (wcnt == LAST);
    assign out_free = !m_valid || m_ready;
    assign rd_en    = out_free && full[rb];
    assign rd_last  = rd_en && (rcnt == LAST);
    assign idle     = (full == 2'b00) && !m_valid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wb][wcnt] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb   <= 1'b0;
            wcnt <= '0;
        end else if (wr_en) begin
            if (wcnt == LAST) begin
                wcnt <= '0;
                wb   <= !wb;
            end else begin
                wcnt <= wcnt + ONE;
            end
        end
    end

    // A write and a read only ever touch different banks, so both updates apply.
    always_comb begin
        full_nxt = full;
        if (wr_last) begin
            full_nxt[wb] = 1'b1;
        end
        if (rd_last) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb      <= 1'b0;
            rcnt    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (out_free) begin
            if (full[rb]) begin
                m_data  <= mem[rb][rcnt];
                m_valid <= 1'b1;
                if (rcnt == LAST) begin
                    rcnt <= '0;
                    rb   <= !rb;
                end else begin
                    rcnt <= rcnt + ONE;
                end
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef VEC_TX_LAST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            m_last <= 1'b0;
        end else if (rd_en) begin
            m_last <= (rcnt == LAST);
        end
    end
`endif

endmodule
